pixel_spike_encoder: RTL and testbench
======================================

# pixel_spike_encoder

Rate-codes one column of HEIGHT pixel intensities (WIDTH bits each) into a single serial spike stream, one bit per clock. It is the transmitting end of the serial `pixel` interface consumed by the perceptron output neurons. Each pixel owns a window of MAX = 2^WIDTH − 1 cycles and emits exactly its intensity in spikes inside that window, so a receiver sees exactly the sum of the intensities. An all-white column therefore saturates a receiver at HEIGHT·MAX.

## Interface
- WIDTH, 8, bits per pixel intensity; MAX = 2^WIDTH − 1 cycles per pixel window
- HEIGHT, 7, pixels per column (frame)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- load_valid  input  1  column data on `pixels` is valid
- load_ready  output  1  encoder idle and able to accept a column
- pixels  input  HEIGHT·WIDTH  pixel i at bits [i·WIDTH +: WIDTH]; pixel 0 sent first
- spike  output  1  serial spike stream; connects to a receiver's `pixel` input
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last window
- spike_count  output  $clog2(HEIGHT·MAX + 1)  spikes emitted in the current or last frame

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: load_ready=1, spike=0. On load_valid && load_ready:
  - capture all pixels into a holding register
  - clear pix_idx, win_cnt, acc and spike_count
  - go to RUN
- RUN: busy=1, load_ready=0. load_valid is ignored and pixels may change freely.
- Per cycle, with v = held intensity of pixel pix_idx and s = acc + v (WIDTH+1 bits):
  - if s ≥ MAX: spike=1 and acc ← s − MAX
  - else: spike=0 and acc ← s
- Distribution check: exactly v spikes per window. v=0 gives none. v=MAX gives every cycle. v=1 gives a spike on the last cycle of the window only.
- win_cnt counts 0..MAX−1. At MAX−1 it wraps to 0, acc clears to 0 and pix_idx increments.
- After the last cycle of window HEIGHT−1, the FSM goes to DONE.
- spike_count increments on every emitted spike and saturates at HEIGHT·MAX. It holds its value after the frame until the next load.
- DONE: frame_done=1 for one cycle, spike=0, busy=0, load_ready=0. Next state is IDLE.

## Timing
- Reset values:
  - FSM=IDLE, so load_ready=1
  - spike=0, busy=0, frame_done=0, spike_count=0
  - acc, win_cnt and pix_idx all 0
- spike is registered. The first spike decision appears in the cycle after the accepting edge.
- A frame is exactly HEIGHT·MAX RUN cycles: 1785 for the defaults.
- frame_done occurs in cycle HEIGHT·MAX + 1 after acceptance.
- load_ready returns in the following cycle, so back-to-back frames have a two-cycle spike=0 gap.
- Reset asserted mid-frame: all outputs and state return to reset values immediately. The partial frame is discarded and is not resumed.
- load_valid held high continuously: a new frame is accepted on the first IDLE cycle.

## Structure
- Shared package snn_pkg holds:
  - function max_val(WIDTH) = 2^WIDTH − 1
  - function count_w(WIDTH, HEIGHT) = $clog2(HEIGHT·max_val + 1); also used by the receiver's balance width
  - the enc_state_t enum {IDLE, RUN, DONE}
- One sub-module, spike_rate_gen:
  - the single-channel accumulator (v, acc clear, step → spike)
  - instantiated once and fed the muxed intensity of pix_idx

## Test plan
- Defaults, all pixels 255 → spike high for 1785 consecutive cycles, spike_count=1785, a receiver reaches its saturated value and asserts neuron_out, then frame_done one cycle later.
- All pixels 0 → spike stays 0 for 1785 cycles, spike_count=0, frame_done at cycle 1786.
- pixel0=1, others 0 → exactly one spike, at RUN cycle 254 (last cycle of window 0), spike_count=1.
- Pixels {128, 64, 0, 255, 1, 2, 3} → per-window spike counts match exactly, total spike_count=453, no window spills into the next.
- Reset pulsed at RUN cycle 500 → spike, busy and spike_count drop to 0 asynchronously and load_ready=1. A fresh all-255 load then gives 1785 spikes.
- load_valid toggled with changing data during RUN → no effect on the stream. load_valid held high → next frame starts exactly 2 cycles after the previous frame's last spike cycle.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking pixel path: sizing helpers and encoder FSM states.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  function automatic int max_val(input int width);
    return int'((32'd1 << width) - 32'd1);
  endfunction

  function automatic int count_w(input int width, input int height);
    return $clog2(height * max_val(width) + 32'sd1);
  endfunction

endpackage

// File: rtl/spike_rate_gen.sv
// Single-channel rate generator: each step adds intensity v to an accumulator and
// spikes whenever the sum reaches MAX, so v spikes land in every MAX-step window.
module spike_rate_gen
  import snn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             restart,
  input  logic             wrap,
  input  logic [WIDTH-1:0] v,
  output logic             spike
);

  localparam logic [WIDTH:0] MAX_S = (WIDTH + 1)'(max_val(WIDTH));

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH:0]   sum_s;

  // Spike decision and next accumulator value for the current step
  always_comb begin
    base_s = restart ? '0 : acc_q;
    sum_s  = {1'b0, base_s} + {1'b0, v};
    spike  = (sum_s >= MAX_S);
    if (!step) begin
      acc_d = acc_q;
    end else if (wrap) begin
      acc_d = '0;
    end else if (spike) begin
      acc_d = WIDTH'(sum_s - MAX_S);
    end else begin
      acc_d = sum_s[WIDTH-1:0];
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pixel_spike_encoder.sv
// Serialises a column of HEIGHT pixel intensities into one rate-coded spike stream,
// one MAX-cycle window per pixel, pixel 0 first.
module pixel_spike_encoder
  import snn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic [HEIGHT*WIDTH-1:0]              pixels,
  output logic                                 spike,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [count_w(WIDTH, HEIGHT)-1:0]    spike_count
);

  localparam int CNT_W = count_w(WIDTH, HEIGHT);
  localparam int PIX_W = $clog2(HEIGHT + 1);
  localparam logic [WIDTH-1:0] WIN_LAST = WIDTH'(max_val(WIDTH) - 1);
  localparam logic [PIX_W-1:0] PIX_END  = PIX_W'(HEIGHT);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HEIGHT * max_val(WIDTH));

  enc_state_t                     state_q, state_d;
  logic [HEIGHT-1:0][WIDTH-1:0]   held_q, held_d;
  logic [PIX_W-1:0]               pix_idx_q, pix_idx_d;
  logic [WIDTH-1:0]               win_cnt_q, win_cnt_d;
  logic                           spike_q, spike_d;
  logic                           busy_q, busy_d;
  logic                           frame_done_q, frame_done_d;
  logic                           load_ready_q, load_ready_d;
  logic [CNT_W-1:0]               spike_count_q, spike_count_d;

  logic                           accept_s;
  logic                           step_s;
  logic                           wrap_s;
  logic [PIX_W-1:0]               pix_sel_s;
  logic [WIDTH-1:0]               v_s;
  logic                           gen_spike_s;

  // pix_idx/win_cnt address the next decision; the decision for (0,0) is taken on
  // the accepting edge straight from the input bus so spike is valid one cycle later.
  always_comb begin
    accept_s  = (state_q == IDLE) && load_valid && load_ready_q;
    step_s    = accept_s || ((state_q == RUN) && (pix_idx_q != PIX_END));
    wrap_s    = (win_cnt_q == WIN_LAST);
    pix_sel_s = (pix_idx_q < PIX_END) ? pix_idx_q : '0;
    v_s       = accept_s ? pixels[WIDTH-1:0] : held_q[pix_sel_s];
  end

  spike_rate_gen #(
    .WIDTH (WIDTH)
  ) u_gen (
    .clk     (clk),
    .rst     (rst),
    .step    (step_s),
    .restart (accept_s),
    .wrap    (wrap_s),
    .v       (v_s),
    .spike   (gen_spike_s)
  );

  // Next-state and registered-output logic for the frame FSM
  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    pix_idx_d     = pix_idx_q;
    win_cnt_d     = win_cnt_q;
    spike_d       = 1'b0;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    load_ready_d  = load_ready_q;
    spike_count_d = spike_count_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          held_d        = pixels;
          state_d       = RUN;
          busy_d        = 1'b1;
          load_ready_d  = 1'b0;
          spike_d       = gen_spike_s;
          spike_count_d = gen_spike_s ? CNT_W'(1) : '0;
        end else begin
          busy_d       = 1'b0;
          load_ready_d = 1'b1;
        end
      end
      RUN: begin
        if (pix_idx_q == PIX_END) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          pix_idx_d    = '0;
          win_cnt_d    = '0;
        end else begin
          spike_d = gen_spike_s;
          if (gen_spike_s && (spike_count_q != CNT_SAT)) begin
            spike_count_d = spike_count_q + CNT_W'(1);
          end else begin
            spike_count_d = spike_count_q;
          end
        end
      end
      DONE: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
        pix_idx_d    = '0;
        win_cnt_d    = '0;
      end
    endcase

    if (step_s) begin
      if (wrap_s) begin
        win_cnt_d = '0;
        pix_idx_d = pix_idx_q + PIX_W'(1);
      end else begin
        win_cnt_d = win_cnt_q + WIDTH'(1);
      end
    end else begin
      win_cnt_d = win_cnt_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      held_q        <= '0;
      pix_idx_q     <= '0;
      win_cnt_q     <= '0;
      spike_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      load_ready_q  <= 1'b1;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      pix_idx_q     <= pix_idx_d;
      win_cnt_q     <= win_cnt_d;
      spike_q       <= spike_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      load_ready_q  <= load_ready_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign spike       = spike_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_pixel_spike_encoder.sv
// Scoreboard bench for pixel_spike_encoder: a window-level rate model queues the
// expected spike train per accepted column; a negedge monitor pops and compares.
module tb_pixel_spike_encoder;

  localparam int W   = 8;
  localparam int H   = 7;
  localparam int MAX = 255;
  localparam int CW  = 11;

  typedef logic [W-1:0] frame_t [H];

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [H*W-1:0] pixels;
  logic          spike;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] spike_count;

  int  pass_cnt  = 0;
  int  total_cnt = 0;
  bit  exp_spk[$];
  int  exp_cnt[$];
  bit  b2b_chk   = 1'b0;

  pixel_spike_encoder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .pixels      (pixels),
    .spike       (spike),
    .busy        (busy),
    .frame_done  (frame_done),
    .spike_count (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // A pixel of value v spikes in window cycle k iff floor((k+1)v/MAX) > floor(kv/MAX)
  task automatic push_model(input frame_t f);
    int total;
    total = 0;
    for (int p = 0; p < H; p++) begin
      int v;
      v = int'(f[p]);
      total += v;
      for (int k = 0; k < MAX; k++) exp_spk.push_back(((k + 1) * v) / MAX > (k * v) / MAX);
    end
    exp_cnt.push_back(total);
  endtask

  task automatic send(input frame_t f, input bit hold);
    int guard;
    @(negedge clk);
    load_valid = 1'b1;
    for (int p = 0; p < H; p++) pixels[p*W +: W] = f[p];
    guard = 0;
    while (!load_ready && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8000) chk("wait_load_ready", load_ready, 1);
    @(posedge clk);
    #1;
    push_model(f);
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((exp_cnt.size() != 0 || exp_spk.size() != 0) && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8000) chk("frame_timeout", exp_cnt.size(), 0);
  endtask

  task automatic noise(input int n);
    repeat (n) begin
      @(negedge clk);
      load_valid = 1'($urandom_range(0, 1));
      pixels     = (H*W)'({$urandom(), $urandom()});
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  function automatic frame_t fill(input int v);
    frame_t f;
    for (int p = 0; p < H; p++) f[p] = W'(v);
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int p = 0; p < H; p++) f[p] = W'($urandom_range(0, MAX));
    return f;
  endfunction

  // Monitor: compares every DUT cycle against the queued expectation
  initial begin
    int  run_len;
    int  gap;
    int  last_total;
    bit  prev_busy;
    bit  e;
    run_len = 0; gap = 0; last_total = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_spk.delete();
        exp_cnt.delete();
        run_len = 0; gap = 0; last_total = 0; prev_busy = 1'b0;
        chk("rst_spike", spike, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_spike_count", spike_count, 0);
        chk("rst_load_ready", load_ready, 1);
      end else begin
        if (busy) begin
          if (!prev_busy) begin
            chk("ready_in_run", load_ready, 0);
            if (b2b_chk) chk("b2b_gap", gap, 2);
          end
          gap = 0;
          run_len++;
          if (exp_spk.size() == 0) begin
            chk("run_too_long", run_len, H * MAX);
          end else begin
            e = exp_spk.pop_front();
            chk("spike", spike, e);
          end
        end else begin
          gap++;
          chk("idle_spike", spike, 0);
          if (!frame_done) chk("count_hold", spike_count, last_total);
        end
        if (frame_done) begin
          chk("frame_len", run_len, H * MAX);
          chk("done_after_run", prev_busy, 1);
          chk("done_busy", busy, 0);
          chk("done_ready", load_ready, 0);
          chk("leftover_spikes", exp_spk.size(), 0);
          if (exp_cnt.size() == 0) begin
            chk("stray_frame_done", exp_cnt.size(), 1);
          end else begin
            last_total = exp_cnt.pop_front();
            chk("spike_count", spike_count, last_total);
          end
          run_len = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // Stimulus sequence
  initial begin
    frame_t f;
    frame_t g;
    rst        = 1'b1;
    load_valid = 1'b0;
    pixels     = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    send(fill(255), 1'b0); wait_done();
    send(fill(0), 1'b0);   wait_done();

    f = fill(0); f[0] = 8'd1;
    send(f, 1'b0); wait_done();

    f[0] = 8'd128; f[1] = 8'd64; f[2] = 8'd0; f[3] = 8'd255;
    f[4] = 8'd1;   f[5] = 8'd2;  f[6] = 8'd3;
    send(f, 1'b0); wait_done();

    for (int n = 0; n < 2; n++) begin
      send(rand_frame(), 1'b0);
      noise(1500);
      wait_done();
    end

    send(fill(255), 1'b0);
    repeat (500) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;
    send(fill(255), 1'b0); wait_done();

    f = rand_frame();
    g = rand_frame();
    send(f, 1'b1);
    @(negedge clk);
    #1 b2b_chk = 1'b1;
    send(g, 1'b0);
    wait_done();
    b2b_chk = 1'b0;

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
